// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: LANES independent radix-2 butterflies (x1 +/- W*x2) in three
// register stages (multiply, combine, round/saturate) with valid/ready flow control.
module fft_bfly_pipe #(
  parameter int DATA_WID = 16,
  parameter int WN_WID   = 16,
  parameter int ACC_LEN  = 14,
  parameter int LANES    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [1:0]                  scale_i,
  input  logic [LANES*DATA_WID-1:0]   x1_re_i,
  input  logic [LANES*DATA_WID-1:0]   x1_im_i,
  input  logic [LANES*DATA_WID-1:0]   x2_re_i,
  input  logic [LANES*DATA_WID-1:0]   x2_im_i,
  input  logic [LANES*WN_WID-1:0]     wn_re_i,
  input  logic [LANES*WN_WID-1:0]     wn_im_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LANES*DATA_WID-1:0]   y1_re_o,
  output logic [LANES*DATA_WID-1:0]   y1_im_o,
  output logic [LANES*DATA_WID-1:0]   y2_re_o,
  output logic [LANES*DATA_WID-1:0]   y2_im_o,
  output logic                        out_ovf_o,
  output logic                        ovf_sticky_o,
  input  logic                        ovf_clr_i
);

  localparam int PW = DATA_WID + WN_WID;
  localparam int AW = PW + 2;
  localparam int LW = LANES * DATA_WID;
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-DATA_WID+1){1'b1}}, {(DATA_WID-1){1'b0}}};

  // Returns {clamped, value}: drop ACC_LEN+s fraction bits, round half up, saturate.
  function automatic logic [DATA_WID:0] rnd_sat(input logic signed [AW-1:0] a,
                                                 input logic [1:0] s);
    logic signed [AW-1:0] sh;
    logic signed [AW-1:0] r;
    logic                 rb;
    logic [DATA_WID:0]    res;
    case (s)
      2'd0: begin
        sh = a >>> ACC_LEN;
        rb = a[ACC_LEN-1];
      end
      2'd1: begin
        sh = a >>> (ACC_LEN + 1);
        rb = a[ACC_LEN];
      end
      default: begin
        sh = a >>> (ACC_LEN + 2);
        rb = a[ACC_LEN+1];
      end
    endcase
    r = sh + $signed({{(AW-1){1'b0}}, rb});
    if (r > SAT_HI) begin
      res = {1'b1, SAT_HI[DATA_WID-1:0]};
    end else if (r < SAT_LO) begin
      res = {1'b1, SAT_LO[DATA_WID-1:0]};
    end else begin
      res = {1'b0, r[DATA_WID-1:0]};
    end
    return res;
  endfunction

  logic                       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                       ld1_s, ld2_s, ld3_s;
  logic [1:0]                 sc1_q, sc1_d, sc2_q, sc2_d;
  logic signed [PW-1:0]       prr_q [LANES];
  logic signed [PW-1:0]       prr_d [LANES];
  logic signed [PW-1:0]       pii_q [LANES];
  logic signed [PW-1:0]       pii_d [LANES];
  logic signed [PW-1:0]       pri_q [LANES];
  logic signed [PW-1:0]       pri_d [LANES];
  logic signed [PW-1:0]       pir_q [LANES];
  logic signed [PW-1:0]       pir_d [LANES];
  logic signed [DATA_WID-1:0] x1re_q [LANES];
  logic signed [DATA_WID-1:0] x1re_d [LANES];
  logic signed [DATA_WID-1:0] x1im_q [LANES];
  logic signed [DATA_WID-1:0] x1im_d [LANES];
  logic signed [AW-1:0]       tr_s [LANES];
  logic signed [AW-1:0]       ti_s [LANES];
  logic signed [AW-1:0]       xr_s [LANES];
  logic signed [AW-1:0]       xi_s [LANES];
  logic signed [AW-1:0]       a1re_q [LANES];
  logic signed [AW-1:0]       a1re_d [LANES];
  logic signed [AW-1:0]       a1im_q [LANES];
  logic signed [AW-1:0]       a1im_d [LANES];
  logic signed [AW-1:0]       a2re_q [LANES];
  logic signed [AW-1:0]       a2re_d [LANES];
  logic signed [AW-1:0]       a2im_q [LANES];
  logic signed [AW-1:0]       a2im_d [LANES];
  logic [DATA_WID:0]          r1re_s [LANES];
  logic [DATA_WID:0]          r1im_s [LANES];
  logic [DATA_WID:0]          r2re_s [LANES];
  logic [DATA_WID:0]          r2im_s [LANES];
  logic                       ovf_s;
  logic [LW-1:0]              y1_re_q, y1_re_d, y1_im_q, y1_im_d;
  logic [LW-1:0]              y2_re_q, y2_re_d, y2_im_q, y2_im_d;
  logic                       ovf_q, ovf_d, sticky_q, sticky_d;

  // Stage load enables: a stage loads when empty or when its successor loads.
  always_comb begin
    ld3_s = ~v3_q | out_ready_i;
    ld2_s = ~v2_q | ld3_s;
    ld1_s = ~v1_q | ld2_s;
  end

  assign in_ready_o   = ld1_s;
  assign out_valid_o  = v3_q;
  assign out_ovf_o    = ovf_q;
  assign ovf_sticky_o = sticky_q;
  assign y1_re_o      = y1_re_q;
  assign y1_im_o      = y1_im_q;
  assign y2_re_o      = y2_re_q;
  assign y2_im_o      = y2_im_q;

  // Stage 1: partial products, x1 and effective scale (3 folds onto 2).
  always_comb begin
    v1_d  = v1_q;
    sc1_d = sc1_q;
    for (int k = 0; k < LANES; k++) begin
      prr_d[k]  = prr_q[k];
      pii_d[k]  = pii_q[k];
      pri_d[k]  = pri_q[k];
      pir_d[k]  = pir_q[k];
      x1re_d[k] = x1re_q[k];
      x1im_d[k] = x1im_q[k];
    end
    if (ld1_s) begin
      v1_d  = in_valid_i;
      sc1_d = (scale_i == 2'd3) ? 2'd2 : scale_i;
      for (int k = 0; k < LANES; k++) begin
        prr_d[k]  = PW'($signed(x2_re_i[k*DATA_WID +: DATA_WID])) * PW'($signed(wn_re_i[k*WN_WID +: WN_WID]));
        pii_d[k]  = PW'($signed(x2_im_i[k*DATA_WID +: DATA_WID])) * PW'($signed(wn_im_i[k*WN_WID +: WN_WID]));
        pri_d[k]  = PW'($signed(x2_re_i[k*DATA_WID +: DATA_WID])) * PW'($signed(wn_im_i[k*WN_WID +: WN_WID]));
        pir_d[k]  = PW'($signed(x2_im_i[k*DATA_WID +: DATA_WID])) * PW'($signed(wn_re_i[k*WN_WID +: WN_WID]));
        x1re_d[k] = $signed(x1_re_i[k*DATA_WID +: DATA_WID]);
        x1im_d[k] = $signed(x1_im_i[k*DATA_WID +: DATA_WID]);
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 operands: twiddle product and x1 aligned to the product's binary point.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      tr_s[k] = AW'(prr_q[k]) - AW'(pii_q[k]);
      ti_s[k] = AW'(pri_q[k]) + AW'(pir_q[k]);
      xr_s[k] = AW'(x1re_q[k]) <<< ACC_LEN;
      xi_s[k] = AW'(x1im_q[k]) <<< ACC_LEN;
    end
  end

  // Stage 2: full-width sum and difference, wide enough that nothing wraps.
  always_comb begin
    v2_d  = v2_q;
    sc2_d = sc2_q;
    for (int k = 0; k < LANES; k++) begin
      a1re_d[k] = a1re_q[k];
      a1im_d[k] = a1im_q[k];
      a2re_d[k] = a2re_q[k];
      a2im_d[k] = a2im_q[k];
    end
    if (ld2_s) begin
      v2_d  = v1_q;
      sc2_d = sc1_q;
      for (int k = 0; k < LANES; k++) begin
        a1re_d[k] = xr_s[k] + tr_s[k];
        a1im_d[k] = xi_s[k] + ti_s[k];
        a2re_d[k] = xr_s[k] - tr_s[k];
        a2im_d[k] = xi_s[k] - ti_s[k];
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Stage 3 operands: rounded and saturated results with per-beat overflow flag.
  always_comb begin
    ovf_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      r1re_s[k] = rnd_sat(a1re_q[k], sc2_q);
      r1im_s[k] = rnd_sat(a1im_q[k], sc2_q);
      r2re_s[k] = rnd_sat(a2re_q[k], sc2_q);
      r2im_s[k] = rnd_sat(a2im_q[k], sc2_q);
      ovf_s = ovf_s | r1re_s[k][DATA_WID] | r1im_s[k][DATA_WID]
                    | r2re_s[k][DATA_WID] | r2im_s[k][DATA_WID];
    end
  end

  // Stage 3: output register, held while the downstream stalls.
  always_comb begin
    v3_d    = v3_q;
    ovf_d   = ovf_q;
    y1_re_d = y1_re_q;
    y1_im_d = y1_im_q;
    y2_re_d = y2_re_q;
    y2_im_d = y2_im_q;
    if (ld3_s) begin
      v3_d  = v2_q;
      ovf_d = v2_q & ovf_s;
      for (int k = 0; k < LANES; k++) begin
        y1_re_d[k*DATA_WID +: DATA_WID] = r1re_s[k][DATA_WID-1:0];
        y1_im_d[k*DATA_WID +: DATA_WID] = r1im_s[k][DATA_WID-1:0];
        y2_re_d[k*DATA_WID +: DATA_WID] = r2re_s[k][DATA_WID-1:0];
        y2_im_d[k*DATA_WID +: DATA_WID] = r2im_s[k][DATA_WID-1:0];
      end
    end else begin
      v3_d = v3_q;
    end
  end

  // Sticky overflow: an overflowing output handshake beats a same-cycle clear.
  always_comb begin
    if (v3_q && out_ready_i && ovf_q) begin
      sticky_d = 1'b1;
    end else if (ovf_clr_i) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // All pipeline state; reset discards in-flight beats and zeroes the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sc1_q    <= 2'd0;
      sc2_q    <= 2'd0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      y1_re_q  <= '0;
      y1_im_q  <= '0;
      y2_re_q  <= '0;
      y2_im_q  <= '0;
      for (int k = 0; k < LANES; k++) begin
        prr_q[k]  <= '0;
        pii_q[k]  <= '0;
        pri_q[k]  <= '0;
        pir_q[k]  <= '0;
        x1re_q[k] <= '0;
        x1im_q[k] <= '0;
        a1re_q[k] <= '0;
        a1im_q[k] <= '0;
        a2re_q[k] <= '0;
        a2im_q[k] <= '0;
      end
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      sc1_q    <= sc1_d;
      sc2_q    <= sc2_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      y1_re_q  <= y1_re_d;
      y1_im_q  <= y1_im_d;
      y2_re_q  <= y2_re_d;
      y2_im_q  <= y2_im_d;
      for (int k = 0; k < LANES; k++) begin
        prr_q[k]  <= prr_d[k];
        pii_q[k]  <= pii_d[k];
        pri_q[k]  <= pri_d[k];
        pir_q[k]  <= pir_d[k];
        x1re_q[k] <= x1re_d[k];
        x1im_q[k] <= x1im_d[k];
        a1re_q[k] <= a1re_d[k];
        a1im_q[k] <= a1im_d[k];
        a2re_q[k] <= a2re_d[k];
        a2im_q[k] <= a2im_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed bench for fft_bfly_pipe: hand-computed butterfly vectors, overflow
// flags, a backpressured random stream against a behavioural model, and reset.
module tb_fft_bfly_pipe;
  localparam int DW = 16;
  localparam int WW = 16;
  localparam int AL = 14;
  localparam int L  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      scale = 2'd0;
  logic [L*DW-1:0] x1_re, x1_im, x2_re, x2_im;
  logic [L*WW-1:0] wn_re, wn_im;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [L*DW-1:0] y1_re, y1_im, y2_re, y2_im;
  logic            out_ovf, ovf_sticky;
  logic            ovf_clr = 1'b0;

  int x1r[L], x1i[L], x2r[L], x2i[L], wr[L], wi[L];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [L*DW-1:0] y1r, y1i, y2r, y2i;
    logic            ovf;
  } exp_t;
  exp_t exp_q[$];

  fft_bfly_pipe #(.DATA_WID(DW), .WN_WID(WW), .ACC_LEN(AL), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .scale_i(scale),
    .x1_re_i(x1_re), .x1_im_i(x1_im), .x2_re_i(x2_re), .x2_im_i(x2_im),
    .wn_re_i(wn_re), .wn_im_i(wn_im),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y1_re_o(y1_re), .y1_im_o(y1_im), .y2_re_o(y2_re), .y2_im_o(y2_im),
    .out_ovf_o(out_ovf), .ovf_sticky_o(ovf_sticky), .ovf_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  always_comb begin
    x1_re = '0; x1_im = '0; x2_re = '0; x2_im = '0; wn_re = '0; wn_im = '0;
    for (int k = 0; k < L; k++) begin
      x1_re[k*DW +: DW] = x1r[k][DW-1:0];
      x1_im[k*DW +: DW] = x1i[k][DW-1:0];
      x2_re[k*DW +: DW] = x2r[k][DW-1:0];
      x2_im[k*DW +: DW] = x2i[k][DW-1:0];
      wn_re[k*WW +: WW] = wr[k][WW-1:0];
      wn_im[k*WW +: WW] = wi[k][WW-1:0];
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input int ar, ai, br, bi, w_r, w_i);
    for (int k = 0; k < L; k++) begin
      x1r[k] = ar; x1i[k] = ai; x2r[k] = br; x2i[k] = bi; wr[k] = w_r; wi[k] = w_i;
    end
  endtask

  task automatic check_lanes(input string tag, input int e1r, e1i, e2r, e2i, input int eovf);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("%s.y1re%0d", tag, k), longint'($signed(y1_re[k*DW +: DW])), e1r);
      chk($sformatf("%s.y1im%0d", tag, k), longint'($signed(y1_im[k*DW +: DW])), e1i);
      chk($sformatf("%s.y2re%0d", tag, k), longint'($signed(y2_re[k*DW +: DW])), e2r);
      chk($sformatf("%s.y2im%0d", tag, k), longint'($signed(y2_im[k*DW +: DW])), e2i);
    end
    chk({tag, ".ovf"}, out_ovf, eovf);
  endtask

  // One beat driven at a negedge; output expected after the third rising edge.
  task automatic single(input string tag, input logic [1:0] sc,
                        input int e1r, e1i, e2r, e2i, input int eovf);
    @(negedge clk);
    scale = sc;
    in_valid = 1'b1;
    #1 chk({tag, ".rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".lat2"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".lat3"}, out_valid, 1);
    check_lanes(tag, e1r, e1i, e2r, e2i, eovf);
  endtask

  function automatic longint rnd_model(input longint a, input int s, inout logic ovf);
    longint r;
    r = (a + (longint'(1) <<< (AL + s - 1))) >>> (AL + s);
    if (r > 32767) begin
      r = 32767; ovf = 1'b1;
    end else if (r < -32768) begin
      r = -32768; ovf = 1'b1;
    end
    return r;
  endfunction

  function automatic exp_t model(input int sc);
    exp_t   e;
    int     s;
    longint tr, ti, v;
    s = (sc > 2) ? 2 : sc;
    e.ovf = 1'b0;
    for (int k = 0; k < L; k++) begin
      tr = longint'(x2r[k]) * wr[k] - longint'(x2i[k]) * wi[k];
      ti = longint'(x2r[k]) * wi[k] + longint'(x2i[k]) * wr[k];
      v = rnd_model(longint'(x1r[k]) * 16384 + tr, s, e.ovf); e.y1r[k*DW +: DW] = v[DW-1:0];
      v = rnd_model(longint'(x1i[k]) * 16384 + ti, s, e.ovf); e.y1i[k*DW +: DW] = v[DW-1:0];
      v = rnd_model(longint'(x1r[k]) * 16384 - tr, s, e.ovf); e.y2r[k*DW +: DW] = v[DW-1:0];
      v = rnd_model(longint'(x1i[k]) * 16384 - ti, s, e.ovf); e.y2i[k*DW +: DW] = v[DW-1:0];
    end
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, fell, inflight, quiet;
    logic rdy, ov, ordy, stalled;
    logic [4*L*DW:0] snap;
    exp_t e_next, e;

    set_all(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.ovf", out_ovf, 0);
    chk("rst.sticky", ovf_sticky, 0);
    chk("rst.y1re", y1_re, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst.ready", in_ready, 1);

    set_all(100, 0, 50, 0, 16384, 0);
    single("ident", 2'd0, 150, 0, 50, 0, 0);
    set_all(100, 0, 50, 0, 0, -16384);
    single("minusj", 2'd0, 100, -50, 100, 50, 0);
    set_all(0, 0, 1, 0, 8192, 0);
    single("half", 2'd0, 1, 0, 0, 0, 0);

    set_all(30000, 0, 30000, 0, 16384, 0);
    single("sat0", 2'd0, 32767, 0, 0, 0, 1);
    @(negedge clk);
    chk("sat0.sticky", ovf_sticky, 1);
    single("sat1", 2'd1, 30000, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat1.sticky", ovf_sticky, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr.sticky", ovf_sticky, 0);
    ovf_clr = 1'b1;
    single("satc", 2'd0, 32767, 0, 0, 0, 1);
    @(negedge clk);
    chk("setwins.sticky", ovf_sticky, 1);
    ovf_clr = 1'b0;

    set_all(1, 0, 0, 0, 16384, 0);
    single("rnd_p1", 2'd1, 1, 0, 1, 0, 0);
    set_all(-1, 0, 0, 0, 16384, 0);
    single("rnd_m1", 2'd1, 0, 0, 0, 0, 0);
    set_all(3, 0, 0, 0, 16384, 0);
    single("rnd_s2", 2'd2, 1, 0, 1, 0, 0);
    single("rnd_s3", 2'd3, 1, 0, 1, 0, 0);

    // Backpressured stream: out_ready low for cycles 4..8.
    sent = 0; got = 0; fell = 0; inflight = -1; stalled = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (!in_valid && sent < 8) begin
        for (int k = 0; k < L; k++) begin
          x1r[k] = int'($urandom_range(0, 65535)) - 32768;
          x1i[k] = int'($urandom_range(0, 65535)) - 32768;
          x2r[k] = int'($urandom_range(0, 65535)) - 32768;
          x2i[k] = int'($urandom_range(0, 65535)) - 32768;
          wr[k]  = int'($urandom_range(0, 32768)) - 16384;
          wi[k]  = int'($urandom_range(0, 32768)) - 16384;
        end
        scale = 2'($urandom_range(0, 3));
        e_next = model(int'(scale));
        in_valid = 1'b1;
      end
      #1;
      rdy = in_ready; ov = out_valid; ordy = out_ready;
      if (stalled)
        chk("bp.hold", (snap == {y1_re, y1_im, y2_re, y2_im, out_ovf}) ? 1 : 0, 1);
      stalled = ov && !ordy;
      snap = {y1_re, y1_im, y2_re, y2_im, out_ovf};
      if (!rdy && fell == 0) begin
        fell = 1;
        inflight = sent - got;
      end
      if (ov && ordy) begin
        if (exp_q.size() == 0) begin
          chk("bp.extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bp%0d.y1re", got), y1_re, e.y1r);
          chk($sformatf("bp%0d.y1im", got), y1_im, e.y1i);
          chk($sformatf("bp%0d.y2re", got), y2_re, e.y2r);
          chk($sformatf("bp%0d.y2im", got), y2_im, e.y2i);
          chk($sformatf("bp%0d.ovf", got), out_ovf, e.ovf);
        end
        got++;
      end
      if (in_valid && rdy) begin
        exp_q.push_back(e_next);
        sent++;
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    chk("bp.count", got, 8);
    chk("bp.fell", fell, 1);
    chk("bp.buffered", inflight, 3);
    out_ready = 1'b1;
    in_valid = 1'b0;

    // Reset with three beats in flight.
    set_all(100, 0, 50, 0, 16384, 0);
    scale = 2'd0;
    @(negedge clk);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("mid.full", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.valid", out_valid, 0);
    chk("mid.y1re", y1_re, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (out_valid) quiet++;
    end
    chk("mid.stale", quiet, 0);
    single("post", 2'd0, 150, 0, 50, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
